bit_stream_serializer: RTL and testbench

//  Parallel-to-serial feeder for the 1011 sequence detector. Accepts WIDTH-bit words

---
 rtl/bit_stream_serializer.sv | 149 ++++++++++++++
 tb/tb_bit_stream_serializer.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/bit_stream_serializer.sv
// bit_stream_serializer: parallel-to-serial feeder for the 1011 sequence detector.
// Words arrive over a load/ready handshake and leave one bit per clock on x.
// A one-word holding register lets back-to-back words stream with no idle gap.
// Optional feature macro: PARITY_EN appends one even-parity bit to every frame.
module bit_stream_serializer #(
  parameter int WIDTH     = 8,
  parameter int LSB_FIRST = 0,
  parameter bit IDLE_BIT  = 1'b0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  input  logic             load,
  output logic             ready,
  output logic             x,
  output logic             x_valid,
  output logic             frame_done
);

`ifdef PARITY_EN
  localparam int FRAME = WIDTH + 1;
`else
  localparam int FRAME = WIDTH;
`endif
  localparam int             CW       = $clog2(WIDTH + 1);
  localparam logic [CW-1:0]  LAST_CNT = CW'(FRAME - 1);

  typedef enum logic {S_IDLE, S_SHIFT} state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [FRAME-1:0]   frm_q, frm_d;
  logic [WIDTH-1:0]   hold_q, hold_d;
  logic               hold_full_q, hold_full_d;
  logic               x_q, x_d;
  logic               x_valid_q, x_valid_d;
  logic               frame_done_q, frame_done_d;

  logic               accept;
  logic               last_bit;

  // Frame layout is arranged so the first bit to send always sits at the
  // shift-out end of the frame register.
  function automatic logic [FRAME-1:0] frame_of(input logic [WIDTH-1:0] w);
`ifdef PARITY_EN
    if (LSB_FIRST != 0) frame_of = {^w, w};
    else                frame_of = {w, ^w};
`else
    frame_of = w;
`endif
  endfunction

  function automatic logic head_bit(input logic [FRAME-1:0] f);
    head_bit = (LSB_FIRST != 0) ? f[0] : f[FRAME-1];
  endfunction

  // ready depends only on the hold flop, never on load.
  assign ready      = ~hold_full_q;
  assign accept     = load & ~hold_full_q;
  assign last_bit   = (state_q == S_SHIFT) && (cnt_q == LAST_CNT);

  assign x          = x_q;
  assign x_valid    = x_valid_q;
  assign frame_done = frame_done_q;

  // State register: all sequential state, synchronous active-high reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      frm_q        <= '0;
      hold_q       <= '0;
      hold_full_q  <= 1'b0;
      x_q          <= IDLE_BIT;
      x_valid_q    <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      frm_q        <= frm_d;
      hold_q       <= hold_d;
      hold_full_q  <= hold_full_d;
      x_q          <= x_d;
      x_valid_q    <= x_valid_d;
      frame_done_q <= frame_done_d;
    end
  end

  // Next-state logic: frame sequencing, hold fill/drain and the shifter.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    frm_d       = frm_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    case (state_q)
      S_IDLE: begin
        if (hold_full_q) begin
          state_d     = S_SHIFT;
          cnt_d       = '0;
          frm_d       = frame_of(hold_q);
          hold_full_d = 1'b0;
        end else if (accept) begin
          state_d = S_SHIFT;
          cnt_d   = '0;
          frm_d   = frame_of(data_in);
        end
      end
      S_SHIFT: begin
        if (last_bit) begin
          cnt_d = '0;
          // A full hold means ready was low, so no accept can collide here.
          if (hold_full_q) begin
            frm_d       = frame_of(hold_q);
            hold_full_d = 1'b0;
          end else if (accept) begin
            frm_d = frame_of(data_in);
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
          frm_d = (LSB_FIRST != 0) ? (frm_q >> 1) : (frm_q << 1);
          if (accept) begin
            hold_d      = data_in;
            hold_full_d = 1'b1;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Output logic: registered copies of what the next cycle presents.
  always_comb begin
    x_d          = IDLE_BIT;
    x_valid_d    = 1'b0;
    frame_done_d = 1'b0;
    if (state_d == S_SHIFT) begin
      x_d          = head_bit(frm_d);
      x_valid_d    = 1'b1;
      frame_done_d = (cnt_d == LAST_CNT);
    end
  end

endmodule

// File: tb/tb_bit_stream_serializer.sv
// Testbench for bit_stream_serializer: directed vector tables, a hand-written
// LSB-first sequence and a randomized run against a queue-style reference model.
module tb_bit_stream_serializer;
  localparam int W = 4;
`ifdef PARITY_EN
  localparam int FR = W + 1;
`else
  localparam int FR = W;
`endif

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic         rst_a, load_a, rdy_a, x_a, xv_a, fd_a;
  logic [W-1:0] din_a;
  logic         rst_b, load_b, rdy_b, x_b, xv_b, fd_b;
  logic [W-1:0] din_b;

  bit_stream_serializer #(.WIDTH(W), .LSB_FIRST(0), .IDLE_BIT(1'b0)) dut_a (
    .clock(clock), .reset(rst_a), .data_in(din_a), .load(load_a),
    .ready(rdy_a), .x(x_a), .x_valid(xv_a), .frame_done(fd_a));

  bit_stream_serializer #(.WIDTH(W), .LSB_FIRST(1), .IDLE_BIT(1'b1)) dut_b (
    .clock(clock), .reset(rst_b), .data_in(din_b), .load(load_b),
    .ready(rdy_b), .x(x_b), .x_valid(xv_b), .frame_done(fd_b));

  int tests_run    = 0;
  int tests_failed = 0;

  // Observations are packed as {x, x_valid, frame_done, ready}.
  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got x/v/fd/rdy=%b expected %b", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // ---------------- reference model ----------------
  // Per DUT: up to two accepted words (in flight, then waiting) and the index
  // of the frame bit currently presented.
  logic [W-1:0] mw [2][2];
  int           msz [2];
  int           mpos[2];

  function automatic logic fbit(input logic [W-1:0] w, input int i, input bit lsb);
    if (i >= W) return ^w;
    return lsb ? w[i] : w[W-1-i];
  endfunction

  task automatic model_edge(input int d, input bit rst, input bit ld, input logic [W-1:0] din);
    bit acc;
    if (rst) begin
      msz[d]  = 0;
      mpos[d] = 0;
      return;
    end
    acc = ld && (msz[d] < 2);
    if (msz[d] > 0) begin
      mpos[d]++;
      if (mpos[d] == FR) begin
        mpos[d]  = 0;
        mw[d][0] = mw[d][1];
        msz[d]--;
      end
    end
    if (acc) begin
      mw[d][msz[d]] = din;
      msz[d]++;
    end
  endtask

  function automatic logic [3:0] model_out(input int d, input bit lsb, input bit idle);
    if (msz[d] == 0) return {idle, 1'b0, 1'b0, 1'b1};
    return {fbit(mw[d][0], mpos[d], lsb), 1'b1, (mpos[d] == FR - 1), (msz[d] < 2)};
  endfunction

  // ---------------- directed vectors for DUT A ----------------
  typedef struct {
    bit           rst;
    bit           ld;
    logic [W-1:0] din;
    logic [3:0]   exp;
  } vec_t;

  vec_t tv[$];

  task automatic add(input bit r, input bit l, input logic [W-1:0] d, input logic [3:0] e);
    vec_t v;
    v.rst = r; v.ld = l; v.din = d; v.exp = e;
    tv.push_back(v);
  endtask

  initial begin
    rst_a = 1'b1; load_a = 1'b0; din_a = '0;
    rst_b = 1'b1; load_b = 1'b0; din_b = '0;
    msz[0] = 0; msz[1] = 0; mpos[0] = 0; mpos[1] = 0;
    tick();
    tick();
    check("reset_a", {x_a, xv_a, fd_a, rdy_a}, 4'b0001);
    check("reset_b", {x_b, xv_b, fd_b, rdy_b}, 4'b1001);
    rst_a = 1'b0; rst_b = 1'b0;
    tick();

`ifdef PARITY_EN
    add(0, 1, 4'b1011, 4'b1101); add(0, 0, 0, 4'b0101); add(0, 0, 0, 4'b1101);
    add(0, 0, 0, 4'b1101);       add(0, 0, 0, 4'b1111); add(0, 0, 0, 4'b0001);
    add(0, 1, 4'b0011, 4'b0101); add(0, 0, 0, 4'b0101); add(0, 0, 0, 4'b1101);
    add(0, 0, 0, 4'b1101);       add(0, 0, 0, 4'b0111); add(0, 0, 0, 4'b0001);
`else
    // single word
    add(0, 1, 4'b1011, 4'b1101); add(0, 0, 0, 4'b0101); add(0, 0, 0, 4'b1101);
    add(0, 0, 0, 4'b1111);       add(0, 0, 0, 4'b0001);
    // held second word, rejected offers while ready is low and at the drain edge
    add(0, 1, 4'b1011, 4'b1101); add(0, 0, 0, 4'b0101); add(0, 1, 4'b0110, 4'b1100);
    add(0, 1, 4'b1111, 4'b1110); add(0, 1, 4'b1111, 4'b0101); add(0, 0, 0, 4'b1101);
    add(0, 0, 0, 4'b1101);       add(0, 0, 0, 4'b0111);       add(0, 0, 0, 4'b0001);
    // word accepted on the last bit goes straight to the shifter
    add(0, 1, 4'b1011, 4'b1101); add(0, 0, 0, 4'b0101); add(0, 0, 0, 4'b1101);
    add(0, 0, 0, 4'b1111);       add(0, 1, 4'b0011, 4'b0101); add(0, 0, 0, 4'b0101);
    add(0, 0, 0, 4'b1101);       add(0, 0, 0, 4'b1111);       add(0, 0, 0, 4'b0001);
    // reset mid-frame, reset beats load, then a fresh word
    add(0, 1, 4'b1011, 4'b1101); add(0, 0, 0, 4'b0101); add(1, 0, 0, 4'b0001);
    add(1, 1, 4'b1111, 4'b0001); add(0, 1, 4'b0011, 4'b0101); add(0, 0, 0, 4'b0101);
    add(0, 0, 0, 4'b1101);       add(0, 0, 0, 4'b1111);       add(0, 0, 0, 4'b0001);
`endif

    for (int i = 0; i < tv.size(); i++) begin
      rst_a  = tv[i].rst;
      load_a = tv[i].ld;
      din_a  = tv[i].din;
      tick();
      check($sformatf("vec_a[%0d]", i), {x_a, xv_a, fd_a, rdy_a}, tv[i].exp);
    end
    rst_a = 1'b0; load_a = 1'b0; din_a = '0;
    tick();

    // LSB-first with idle-high on DUT B: 1011 -> 1,1,0,1
    check("b_idle", {x_b, xv_b, fd_b, rdy_b}, 4'b1001);
    load_b = 1'b1; din_b = 4'b1011;
    tick(); check("b_bit0", {x_b, xv_b, fd_b, rdy_b}, 4'b1101);
    load_b = 1'b0; din_b = '0;
    tick(); check("b_bit1", {x_b, xv_b, fd_b, rdy_b}, 4'b1101);
    tick(); check("b_bit2", {x_b, xv_b, fd_b, rdy_b}, 4'b0101);
`ifdef PARITY_EN
    tick(); check("b_bit3", {x_b, xv_b, fd_b, rdy_b}, 4'b1101);
    tick(); check("b_par",  {x_b, xv_b, fd_b, rdy_b}, 4'b1111);
`else
    tick(); check("b_bit3", {x_b, xv_b, fd_b, rdy_b}, 4'b1111);
`endif
    tick(); check("b_idle_after", {x_b, xv_b, fd_b, rdy_b}, 4'b1001);

    // ---------------- randomized run against the model ----------------
    rst_a = 1'b1; rst_b = 1'b1;
    model_edge(0, 1'b1, 1'b0, '0);
    model_edge(1, 1'b1, 1'b0, '0);
    tick();
    for (int c = 0; c < 3000; c++) begin
      rst_a  = ($urandom_range(0, 99) == 0);
      rst_b  = ($urandom_range(0, 99) == 0);
      load_a = ($urandom_range(0, 9) < 6);
      load_b = ($urandom_range(0, 9) < 4);
      din_a  = W'($urandom);
      din_b  = W'($urandom);
      model_edge(0, rst_a, load_a, din_a);
      model_edge(1, rst_b, load_b, din_b);
      tick();
      check($sformatf("rand_a[%0d]", c), {x_a, xv_a, fd_a, rdy_a}, model_out(0, 1'b0, 1'b0));
      check($sformatf("rand_b[%0d]", c), {x_b, xv_b, fd_b, rdy_b}, model_out(1, 1'b1, 1'b1));
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
